turbofm_pro: RTL and testbench

//  CPLD glue for the TurboFM-pro sound card: decodes the AY-3-8910 style host bus and drives two YM2203 chips and one SAA1099.

---
 rtl/turbofm_pkg.sv | 28 ++
 rtl/ay_bus_decoder.sv | 39 +++
 rtl/turbofm_pro.sv | 209 ++++++++++++++++++++
 tb/tb_turbofm_pro.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbofm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turbofm_pkg
//  Description : Shared types and constants for the TurboFM-pro glue logic:
//                AY bus cycle type and control-word bit layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package turbofm_pkg;

    // Host AY bus cycle classification
    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_ADDR  = 2'd1,
        CYC_WRITE = 2'd2,
        CYC_READ  = 2'd3
    } cycle_t;

    // Control register bit positions
    localparam int CTRL_SAA_N = 3;
    localparam int CTRL_DATA  = 1;
    localparam int CTRL_CHIP  = 0;

    // Control register reset value and control-word prefix on ayd[7:4]
    localparam logic [3:0] CTRL_RESET  = 4'hF;
    localparam logic [3:0] CTRL_PREFIX = 4'hF;

endpackage : turbofm_pkg
`default_nettype wire

// File: rtl/ay_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ay_bus_decoder
//  Description : Classifies the host AY bus control lines into a cycle type.
//                Chip is selected when a8=1 and a9_n=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ay_bus_decoder
    import turbofm_pkg::*;
(
    input  logic   i_bdir,
    input  logic   i_bc2,
    input  logic   i_bc1,
    input  logic   i_a8,
    input  logic   i_a9_n,
    output cycle_t o_cyc
);

    logic w_sel;

    assign w_sel = i_a8 & ~i_a9_n;

    // Decode {bdir,bc2,bc1}; an unselected chip always sees an idle bus
    always_comb begin
        o_cyc = CYC_IDLE;
        if (w_sel) begin
            case ({i_bdir, i_bc2, i_bc1})
                3'b001,
                3'b100,
                3'b111:  o_cyc = CYC_ADDR;
                3'b110:  o_cyc = CYC_WRITE;
                3'b011:  o_cyc = CYC_READ;
                default: o_cyc = CYC_IDLE;
            endcase
        end
    end

endmodule : ay_bus_decoder
`default_nettype wire

// File: rtl/turbofm_pro.sv
`default_nettype none
// ============================================================================
//  Module      : turbofm_pro
//  Description : TurboFM-pro CPLD glue. Bridges the host AY bus to two YM2203
//                chips and one SAA1099, intercepts control words written to
//                the AY address port, and divides fclk into the chip clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module turbofm_pro
    import turbofm_pkg::*;
#(
    parameter int YMCLK_DIV  = 8,
    parameter int SAACLK_DIV = 4
) (
    input  logic       fclk,
    input  logic       ayres_n,
    inout  wire  [7:0] ayd,
    inout  wire  [7:0] d,
    input  logic       aybdir,
    input  logic       aybc1,
    input  logic       aybc2,
    input  logic       aya8,
    input  logic       aya9_n,
    input  logic       mode_enable_saa,
    input  logic       mode_enable_ymfm,
    output logic       ymclk,
    output logic       saaclk,
    output logic       ymcs1_n,
    output logic       ymcs2_n,
    output logic       ymrd_n,
    output logic       ymwr_n,
    output logic       yma0,
    input  logic       ymop1,
    input  logic       ymop2,
    output logic       ymop1d,
    output logic       ymop2d,
    output logic       saacs_n,
    output logic       saawr_n,
    output logic       saaa0
);

    // Each divider toggles its output every DIV/2 fclk cycles
    localparam int c_ym_half  = YMCLK_DIV / 2;
    localparam int c_saa_half = SAACLK_DIV / 2;
    localparam int c_ym_w     = (c_ym_half  > 1) ? $clog2(c_ym_half)  : 1;
    localparam int c_saa_w    = (c_saa_half > 1) ? $clog2(c_saa_half) : 1;
    localparam logic [c_ym_w-1:0]  c_ym_last  = c_ym_w'(c_ym_half - 1);
    localparam logic [c_saa_w-1:0] c_saa_last = c_saa_w'(c_saa_half - 1);

    cycle_t            w_cyc;
    logic              w_mode_en;
    logic              w_prefix;
    logic              w_ctrl_word;
    logic              w_saa_mode;
    logic              w_data_rd;
    logic              w_chip1;
    logic              w_drive_d;
    logic              w_drive_ayd;
    logic [7:0]        w_ayd_out;
    logic              w_unused_ctrl;

    logic              r_addr_meta;
    logic              r_addr_sync;
    logic [3:0]        r_ctrl;
    logic [c_ym_w-1:0]  r_ym_cnt;
    logic [c_saa_w-1:0] r_saa_cnt;

    ay_bus_decoder u_dec (
        .i_bdir (aybdir),
        .i_bc2  (aybc2),
        .i_bc1  (aybc1),
        .i_a8   (aya8),
        .i_a9_n (aya9_n),
        .o_cyc  (w_cyc)
    );

    assign w_mode_en   = mode_enable_saa | mode_enable_ymfm;
    assign w_prefix    = (ayd[7:4] == CTRL_PREFIX);
    assign w_ctrl_word = (w_cyc == CYC_ADDR) && w_prefix && w_mode_en;

    // Effective mode after applying the enable straps to the stored bits
    assign w_saa_mode    = ~r_ctrl[CTRL_SAA_N] & mode_enable_saa;
    assign w_data_rd     =  r_ctrl[CTRL_DATA]  | ~mode_enable_ymfm;
    assign w_chip1       =  r_ctrl[CTRL_CHIP]  | ~mode_enable_ymfm;
    // Bit 2 is kept in the register for software read-modify-write symmetry only
    assign w_unused_ctrl = r_ctrl[2];

    // Two-stage synchroniser for the asynchronous ADDR bus level
    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            r_addr_meta <= 1'b0;
            r_addr_sync <= 1'b0;
        end else begin
            r_addr_meta <= (w_cyc == CYC_ADDR);
            r_addr_sync <= r_addr_meta;
        end
    end

    // Control register: reloaded every cycle the synchronised ADDR carries the prefix
    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            r_ctrl <= CTRL_RESET;
        end else if (r_addr_sync && w_prefix && w_mode_en) begin
            r_ctrl <= ayd[3:0];
        end
    end

    // YM clock divider, free running
    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            r_ym_cnt <= '0;
            ymclk    <= 1'b0;
        end else if (r_ym_cnt == c_ym_last) begin
            r_ym_cnt <= '0;
            ymclk    <= ~ymclk;
        end else begin
            r_ym_cnt <= r_ym_cnt + 1'b1;
        end
    end

    // SAA clock divider, free running
    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            r_saa_cnt <= '0;
            saaclk    <= 1'b0;
        end else if (r_saa_cnt == c_saa_last) begin
            r_saa_cnt <= '0;
            saaclk    <= ~saaclk;
        end else begin
            r_saa_cnt <= r_saa_cnt + 1'b1;
        end
    end

    // Retime the YM serial outputs onto fclk
    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            ymop1d <= 1'b0;
            ymop2d <= 1'b0;
        end else begin
            ymop1d <= ymop1;
            ymop2d <= ymop2;
        end
    end

    // Strobe and bus-direction muxing; held for the whole bus phase
    always_comb begin
        ymcs1_n     = 1'b1;
        ymcs2_n     = 1'b1;
        ymrd_n      = 1'b1;
        ymwr_n      = 1'b1;
        yma0        = 1'b0;
        saacs_n     = 1'b1;
        saawr_n     = 1'b1;
        saaa0       = 1'b0;
        w_drive_d   = 1'b0;
        w_drive_ayd = 1'b0;
        w_ayd_out   = 8'hFF;
        case (w_cyc)
            CYC_ADDR: begin
                if (!w_ctrl_word) begin
                    w_drive_d = 1'b1;
                    if (w_saa_mode) begin
                        saacs_n = 1'b0;
                        saawr_n = 1'b0;
                        saaa0   = 1'b1;
                    end else begin
                        ymcs1_n = ~w_chip1;
                        ymcs2_n =  w_chip1;
                        ymwr_n  = 1'b0;
                        yma0    = 1'b0;
                    end
                end
            end
            CYC_WRITE: begin
                w_drive_d = 1'b1;
                if (w_saa_mode) begin
                    saacs_n = 1'b0;
                    saawr_n = 1'b0;
                    saaa0   = 1'b0;
                end else begin
                    ymcs1_n = ~w_chip1;
                    ymcs2_n =  w_chip1;
                    ymwr_n  = 1'b0;
                    yma0    = 1'b1;
                end
            end
            CYC_READ: begin
                w_drive_ayd = 1'b1;
                if (w_saa_mode) begin
                    w_ayd_out = 8'hFF;
                end else begin
                    ymcs1_n   = ~w_chip1;
                    ymcs2_n   =  w_chip1;
                    ymrd_n    = 1'b0;
                    yma0      = w_data_rd;
                    w_ayd_out = d;
                end
            end
            default: begin
            end
        endcase
    end

    // Bus drivers: direction flags are mutually exclusive by construction
    assign d   = w_drive_d   ? ayd       : 8'hzz;
    assign ayd = w_drive_ayd ? w_ayd_out : 8'hzz;

endmodule : turbofm_pro
`default_nettype wire

// File: tb/tb_turbofm_pro.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turbofm_pro
//  Description : Directed self-checking bench for turbofm_pro. Both buses
//                have pull-downs so a released bus reads back as 8'h00.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_turbofm_pro;

    // Strobe vector order: {ymcs1_n,ymcs2_n,ymrd_n,ymwr_n,yma0,saacs_n,saawr_n,saaa0}
    localparam logic [7:0] c_st_idle   = 8'b1111_0110;
    localparam logic [7:0] c_st_ym1_a  = 8'b0110_0110;
    localparam logic [7:0] c_st_ym1_w  = 8'b0110_1110;
    localparam logic [7:0] c_st_ym2_rs = 8'b1001_0110;
    localparam logic [7:0] c_st_ym1_rd = 8'b0101_1110;
    localparam logic [7:0] c_st_saa_a  = 8'b1111_0001;
    localparam logic [7:0] c_st_saa_w  = 8'b1111_0000;

    localparam logic [2:0] c_addr  = 3'b111;
    localparam logic [2:0] c_write = 3'b110;
    localparam logic [2:0] c_read  = 3'b011;
    localparam logic [2:0] c_idle  = 3'b000;

    logic fclk, ayres_n;
    logic aybdir, aybc1, aybc2, aya8, aya9_n;
    logic mode_enable_saa, mode_enable_ymfm;
    logic ymclk, saaclk, ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0;
    logic ymop1, ymop2, ymop1d, ymop2d;
    logic saacs_n, saawr_n, saaa0;

    logic       r_host_oe;
    logic [7:0] r_host_data;
    logic       r_chip_oe;
    logic [7:0] r_chip_data;

    wire  [7:0] ayd;
    wire  [7:0] d;
    logic [7:0] w_strobes;

    int n_checks = 0;
    int n_errors = 0;

    assign ayd = r_host_oe ? r_host_data : 8'hzz;
    assign d   = r_chip_oe ? r_chip_data : 8'hzz;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pd
            pulldown pd_ayd (ayd[gi]);
            pulldown pd_d   (d[gi]);
        end
    endgenerate

    assign w_strobes = {ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0, saacs_n, saawr_n, saaa0};

    turbofm_pro #(
        .YMCLK_DIV  (8),
        .SAACLK_DIV (4)
    ) dut (
        .fclk             (fclk),
        .ayres_n          (ayres_n),
        .ayd              (ayd),
        .d                (d),
        .aybdir           (aybdir),
        .aybc1            (aybc1),
        .aybc2            (aybc2),
        .aya8             (aya8),
        .aya9_n           (aya9_n),
        .mode_enable_saa  (mode_enable_saa),
        .mode_enable_ymfm (mode_enable_ymfm),
        .ymclk            (ymclk),
        .saaclk           (saaclk),
        .ymcs1_n          (ymcs1_n),
        .ymcs2_n          (ymcs2_n),
        .ymrd_n           (ymrd_n),
        .ymwr_n           (ymwr_n),
        .yma0             (yma0),
        .ymop1            (ymop1),
        .ymop2            (ymop2),
        .ymop1d           (ymop1d),
        .ymop2d           (ymop2d),
        .saacs_n          (saacs_n),
        .saawr_n          (saawr_n),
        .saaa0            (saaa0)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Start a bus phase and let it settle past the control-word capture latency
    task automatic phase(input logic [2:0] code, input logic a8, input logic a9n,
                         input logic [7:0] data, input logic host_oe);
        {aybdir, aybc2, aybc1} = code;
        aya8        = a8;
        aya9_n      = a9n;
        r_host_data = data;
        r_host_oe   = host_oe;
        repeat (4) @(posedge fclk);
        #1;
    endtask

    task automatic bus_idle();
        {aybdir, aybc2, aybc1} = c_idle;
        r_host_oe = 1'b0;
        r_chip_oe = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
    endtask

    // Rising-edge positions of ymclk or saaclk, counted in fclk edges
    task automatic measure_clk(input bit sel_saa, output int first_rise, output int period);
        logic prev, cur;
        int   rises [2];
        int   n;
        n          = 0;
        first_rise = -1;
        period     = -1;
        prev       = sel_saa ? saaclk : ymclk;
        for (int c = 1; c <= 64 && n < 2; c++) begin
            @(posedge fclk);
            #1;
            cur = sel_saa ? saaclk : ymclk;
            if (cur && !prev) begin
                rises[n] = c;
                n++;
            end
            prev = cur;
        end
        if (n == 2) begin
            first_rise = rises[0];
            period     = rises[1] - rises[0];
        end
    endtask

    initial begin
        int fr, per;
        logic [2:0] idle_codes [3];
        idle_codes[0] = 3'b000;
        idle_codes[1] = 3'b010;
        idle_codes[2] = 3'b101;

        ayres_n          = 1'b0;
        {aybdir, aybc2, aybc1} = c_idle;
        aya8             = 1'b1;
        aya9_n           = 1'b0;
        mode_enable_saa  = 1'b1;
        mode_enable_ymfm = 1'b1;
        ymop1            = 1'b1;
        ymop2            = 1'b0;
        r_host_oe        = 1'b0;
        r_host_data      = 8'h00;
        r_chip_oe        = 1'b0;
        r_chip_data      = 8'h00;

        // Reset state
        repeat (4) @(posedge fclk);
        #1;
        check_val("rst_clks",    {6'd0, ymclk, saaclk}, 8'h00);
        check_val("rst_ymop",    {6'd0, ymop1d, ymop2d}, 8'h00);
        check_val("rst_strobes", w_strobes, c_st_idle);
        check_val("rst_d",       d,   8'h00);
        check_val("rst_ayd",     ayd, 8'h00);

        @(negedge fclk);
        ayres_n = 1'b1;
        measure_clk(1'b0, fr, per);
        check_val("ym_first_rise", 8'(fr),  8'd4);
        check_val("ym_period",     8'(per), 8'd8);
        measure_clk(1'b1, fr, per);
        check_val("saa_period",    8'(per), 8'd4);
        check_val("ymop_retime",   {6'd0, ymop1d, ymop2d}, 8'b10);
        check_val("idle_strobes",  w_strobes, c_st_idle);

        // YM write to chip 1
        phase(c_addr, 1'b1, 1'b0, 8'h07, 1'b1);
        check_val("ym_addr_st", w_strobes, c_st_ym1_a);
        check_val("ym_addr_d",  d, 8'h07);
        bus_idle();
        check_val("ym_gap_st",  w_strobes, c_st_idle);
        phase(c_write, 1'b1, 1'b0, 8'h38, 1'b1);
        check_val("ym_data_st", w_strobes, c_st_ym1_w);
        check_val("ym_data_d",  d, 8'h38);
        bus_idle();

        // Chip 2, status read
        phase(c_addr, 1'b1, 1'b0, 8'hFC, 1'b1);
        check_val("ctl_fc_st", w_strobes, c_st_idle);
        check_val("ctl_fc_d",  d, 8'h00);
        bus_idle();
        r_chip_data = 8'h80;
        r_chip_oe   = 1'b1;
        phase(c_read, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("ym2_rd_st",  w_strobes, c_st_ym2_rs);
        check_val("ym2_rd_ayd", ayd, 8'h80);
        bus_idle();

        // SAA mode
        phase(c_addr, 1'b1, 1'b0, 8'hF7, 1'b1);
        check_val("ctl_f7_st", w_strobes, c_st_idle);
        bus_idle();
        phase(c_addr, 1'b1, 1'b0, 8'h1C, 1'b1);
        check_val("saa_addr_st", w_strobes, c_st_saa_a);
        check_val("saa_addr_d",  d, 8'h1C);
        bus_idle();
        phase(c_write, 1'b1, 1'b0, 8'h01, 1'b1);
        check_val("saa_data_st", w_strobes, c_st_saa_w);
        check_val("saa_data_d",  d, 8'h01);
        bus_idle();
        phase(c_read, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("saa_rd_st",  w_strobes, c_st_idle);
        check_val("saa_rd_ayd", ayd, 8'hFF);
        bus_idle();
        mode_enable_saa = 1'b0;
        phase(c_addr, 1'b1, 1'b0, 8'h1C, 1'b1);
        check_val("nosaa_addr_st", w_strobes, c_st_ym1_a);
        check_val("nosaa_addr_d",  d, 8'h1C);
        bus_idle();

        // Unselected chip and idle control codes
        phase(c_write, 1'b0, 1'b0, 8'h55, 1'b1);
        check_val("a8lo_st", w_strobes, c_st_idle);
        check_val("a8lo_d",  d, 8'h00);
        bus_idle();
        phase(c_write, 1'b1, 1'b1, 8'h55, 1'b1);
        check_val("a9hi_st", w_strobes, c_st_idle);
        check_val("a9hi_d",  d, 8'h00);
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            phase(idle_codes[i], 1'b1, 1'b0, 8'h55, 1'b1);
            check_val($sformatf("code%0b_st", idle_codes[i]), w_strobes, c_st_idle);
            check_val($sformatf("code%0b_d",  idle_codes[i]), d, 8'h00);
            bus_idle();
        end

        // Mid-cycle reset: ctrl must fall back to chip 1 / data reads
        phase(c_addr, 1'b1, 1'b0, 8'hFC, 1'b1);
        bus_idle();
        phase(c_addr, 1'b1, 1'b0, 8'hFE, 1'b1);
        ayres_n = 1'b0;
        #2;
        check_val("rstmid_addr_st", w_strobes, c_st_idle);
        phase(c_write, 1'b1, 1'b0, 8'h00, 1'b1);
        check_val("rstmid_wr_st", w_strobes, c_st_ym1_w);
        bus_idle();
        @(negedge fclk);
        ayres_n = 1'b1;
        repeat (2) @(posedge fclk);
        r_chip_data = 8'h5A;
        r_chip_oe   = 1'b1;
        phase(c_read, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("postrst_rd_st",  w_strobes, c_st_ym1_rd);
        check_val("postrst_rd_ayd", ayd, 8'h5A);
        bus_idle();

        // Without the FM enable, stored chip/status bits are overridden
        phase(c_addr, 1'b1, 1'b0, 8'hFC, 1'b1);
        bus_idle();
        mode_enable_ymfm = 1'b0;
        r_chip_data = 8'h33;
        r_chip_oe   = 1'b1;
        phase(c_read, 1'b1, 1'b0, 8'h00, 1'b0);
        check_val("nofm_rd_st",  w_strobes, c_st_ym1_rd);
        check_val("nofm_rd_ayd", ayd, 8'h33);
        bus_idle();
        phase(c_addr, 1'b1, 1'b0, 8'hFC, 1'b1);
        check_val("nofm_addr_st", w_strobes, c_st_ym1_a);
        check_val("nofm_addr_d",  d, 8'hFC);
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_turbofm_pro
`default_nettype wire
